// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit timing and parity helpers.
// Used by both the transmitter and the receiver so frame settings stay matched.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned BIT_CNT_W = 4;

    function automatic int unsigned calc_bit_cycles(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

    // data_xor is the XOR of all data bits
    function automatic logic parity_bit(
        input logic data_xor,
        input logic odd
    );
        return data_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable bit-period down-counter; o_bit_end marks the last cycle of a bit.
// Shared by the UART transmitter and receiver.
module uart_baud_counter #(
    parameter int unsigned BIT_CYCLES = 10
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_load,
    output logic o_bit_end
);

    localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_bit_end = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, one-entry holding register,
// LSB-first serial output with optional parity and 0..2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 25_000_000,
    parameter int unsigned BAUD_RATE     = 9_600,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY_BIT    = 0,
    parameter int unsigned ODD_PARITY    = 1,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned BIT_CYCLES =
        calc_bit_cycles(CLOCK_FREQ_HZ, BAUD_RATE);

    localparam logic [BIT_CNT_W-1:0] DATA_LAST =
        BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST =
        (STOP_BITS > 0) ? BIT_CNT_W'(STOP_BITS - 1) : '0;

    generate
        if (BIT_CYCLES < 2) begin : g_bad_baud
            $error("uart_tx: BIT_CYCLES must be at least 2");
        end
    endgenerate

    state_t                 state;
    state_t                 state_n;
    logic                   full;
    logic [DATA_BITS-1:0]   hold;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   bit_end;
    logic                   load;
    logic                   transfer;
    logic                   frame_end;
    logic                   accept;
    logic                   done_q;
    logic                   tx_n;

    assign o_ready = !full;
    assign accept  = i_valid && !full;
    assign load    = transfer || ((state != IDLE) && bit_end);

    uart_baud_counter #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_load    (load),
        .o_bit_end (bit_end)
    );

    always_comb begin
        state_n   = state;
        transfer  = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (full) begin
                    transfer = 1'b1;
                    state_n  = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == DATA_LAST) begin
                    if (PARITY_BIT != 0) state_n = PARITY;
                    else if (STOP_BITS != 0) state_n = STOP;
                    else frame_end = 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (STOP_BITS != 0) state_n = STOP;
                    else frame_end = 1'b1;
                end
            end
            STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) frame_end = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // a queued word starts immediately, with no idle bit
        if (frame_end) begin
            if (full) begin
                transfer = 1'b1;
                state_n  = START;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_comb begin
        tx_n = 1'b1;
        unique case (state)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg[0];
            PARITY:  tx_n = par_q;
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                bit_cnt <= '0;
            end else if (bit_end && (state == DATA || state == STOP)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            full <= 1'b0;
            hold <= '0;
        end else if (accept) begin
            full <= 1'b1;
            hold <= i_data;
        end else if (transfer) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            shreg <= '0;
            par_q <= 1'b0;
        end else if (transfer) begin
            shreg <= hold;
            par_q <= parity_bit(^hold, ODD_PARITY != 0);
        end else if (state == DATA && bit_end) begin
            shreg <= shreg >> 1;
        end
    end

    // outputs lag the state by one cycle so every line bit is a full period
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
            done_q <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_tx   <= tx_n;
            o_busy <= (state != IDLE);
            done_q <= frame_end;
            o_done <= done_q;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter, the transmit-side counterpart to the team's UART receiver, sharing its frame parameters so a matched pair interoperates. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first on `o_tx`: start bit, data bits, optional parity, then stop bits. A one-entry holding register lets the next word be queued during a frame, so consecutive frames run with no idle gap.

## Interface
- `CLOCK_FREQ_HZ`, 25_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9_600: line rate in bits per second.
- `DATA_BITS`, 8: data bits per frame, range 5..9.
- `PARITY_BIT`, 0: 1 inserts a parity bit after the data bits.
- `ODD_PARITY`, 1: 1 selects odd parity, 0 selects even; ignored when `PARITY_BIT`=0.
- `STOP_BITS`, 1: stop bits per frame, range 0..2.
- `i_Clk`  in  1  sole clock; all logic on rising edge.
- `i_Rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_data`  in  DATA_BITS  word to transmit.
- `i_valid`  in  1  `i_data` valid.
- `o_ready`  out  1  holding register empty; a word is accepted when `i_valid && o_ready`.
- `o_tx`  out  1  serial line, idle high, driven from a flop.
- `o_busy`  out  1  high while any frame bit is on the line.
- `o_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- `BIT_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE` (integer division). Every line bit lasts exactly `BIT_CYCLES` clocks. `BIT_CYCLES` < 2 is illegal; flag it at elaboration.
- FSM states:
  - `IDLE`: line high. If the holding register is full, move it to the shift register, clear it, and go to `START`.
  - `START`: drive 0 for one bit, then go to `DATA`.
  - `DATA`: drive the shift register LSB and shift right each bit. After `DATA_BITS` bits, go to `PARITY` if `PARITY_BIT`=1; otherwise go to `STOP`, or to end-of-frame if `STOP_BITS`=0.
  - `PARITY`: drive `^word ^ ODD_PARITY` for one bit. The total count of ones in data plus parity is odd for odd parity and even for even parity. Then go to `STOP`, or end-of-frame.
  - `STOP`: drive 1 for `STOP_BITS` bits, then end-of-frame.
- End-of-frame, in the same cycle as the last bit period expiring:
  - pulse `o_done`.
  - If the holding register is full, go directly to `START` (back-to-back). Otherwise go to `IDLE`.
- Holding register: `o_ready` = !full.
  - Acceptance sets full and captures `i_data`.
  - Acceptance and transfer to the shift register in the same cycle: the holding register stays full with the new word.
- Bit counter counts 0..`DATA_BITS`-1. Its width is sized for 9. It wraps to 0 at each state exit.
- Baud counter loads `BIT_CYCLES`-1 on each bit start and decrements. A value of 0 marks the last cycle of a bit.
- `i_data` changing while `o_ready`=0 has no effect. The transmitted word is the value captured at acceptance.

## Timing
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0. State is `IDLE`, holding register empty, counters 0.
- Reset mid-frame forces `o_tx` high immediately (asynchronously). The partial frame and any queued word are discarded.
- Latency: a word accepted at edge N from `IDLE` with an empty shift path reaches the holding register at N. `IDLE` transfers it at N+1 and `o_tx` falls at N+2.
- Frame length: `(1 + DATA_BITS + PARITY_BIT + STOP_BITS) * BIT_CYCLES` clocks.
- `o_busy` rises with the start bit and falls after the final bit. It stays high across back-to-back frames.
- `o_done` coincides with the first cycle after the final bit period, aligned with `o_tx` entering either idle or the next start bit.
- With `STOP_BITS`=0, back-to-back frames have no high bit between them. This is legal by configuration.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - the `BIT_CYCLES` computation function;
  - the parity-bit function.
- The receiver uses the same package.
- One sub-module, `uart_baud_counter`: loadable down-counter with `i_load`, output `o_bit_end`, width `$clog2(BIT_CYCLES)`. The receiver can reuse it.

## Test plan
- `CLOCK_FREQ_HZ`=1_000_000, `BAUD_RATE`=100_000 (`BIT_CYCLES`=10), 8N1; send 0xA5 -> `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 clocks; `o_done` pulses once 100 clocks after the falling edge.
- 8O1, send 0x07 -> parity bit 0 (three ones already odd); 8E1, send 0x07 -> parity bit 1.
- Queue 0x12, then 0x34 while the first frame is busy -> `o_ready` low until the second word transfers; the second start bit directly follows the first stop bit; `o_busy` stays high throughout.
- Hold `i_valid` high with three words -> exactly three frames, no word dropped or duplicated; `o_ready` never high while the holding register is full.
- Assert `i_Rst_n` low mid-`DATA` -> `o_tx`=1 before the next edge; after release, `o_ready`=1 and no residual frame is sent.
- `DATA_BITS`=5, `STOP_BITS`=2, send 0x1F -> 8 bit periods total; the last two bits are high.
